// File: rtl/rtc_bus_read_ctrl.sv
// rtc_bus_read_ctrl
// Master-side read sequencer for the RTC's multiplexed address/data bus.
// On an accepted start it runs one complete read cycle:
//   ADDR_SET -> ADDR_WR -> ADDR_HOLD -> TURN -> RD_LOW -> RECOVER -> DONE
// Every phase except DONE lasts PHASE_CYCLES clocks. DONE lasts one clock.
// All pin-facing outputs are registered.
//
// Ports
//   clk, rst_n     system clock (rising edge); asynchronous active-low reset
//   start, addr    read request (sampled only in IDLE) and RTC register address
//   data_out       last byte captured from the bus; holds until the next capture
//   busy, done     busy spans accept+1 through DONE; done is a one-cycle pulse
//   bus_in         pad value read back from the shared bus
//   bus_drive      value presented to the external tristate buffer
//   bus_oe         tristate enable (1 = drive bus_drive onto the pins)
//   cs_n           chip select (active low)
//   ad_sel         0 = address phase, 1 = data phase
//   wr_n, rd_n     address strobe and read strobe (both active low)
//   bcd_err        only when RTC_BCD_CHECK_EN is defined; set when either nibble
//                  of the captured byte is above 9
//
// Optional feature macro: RTC_BCD_CHECK_EN
module rtc_bus_read_ctrl #(
    parameter int PHASE_CYCLES = 4,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] bus_in,
    output logic [ADDR_W-1:0] bus_drive,
    output logic              bus_oe,
    output logic              cs_n,
    output logic              ad_sel,
    output logic              wr_n,
    output logic              rd_n
`ifdef RTC_BCD_CHECK_EN
   ,output logic              bcd_err
`endif
);

    typedef enum logic [2:0] {
        IDLE, ADDR_SET, ADDR_WR, ADDR_HOLD, TURN, RD_LOW, RECOVER, DONE
    } state_t;

    // The counter only has to reach PHASE_CYCLES-1. Its width is kept at a minimum of 1 bit.
    localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_end, capture;

    logic [ADDR_W-1:0] drive_d;
    logic              oe_d, cs_n_d, ad_sel_d, wr_n_d, rd_n_d, busy_d, done_d;

    // Next-state logic and phase timing.
    // Each timed state advances when the counter reaches its terminal count.
    // On a state change the counter restarts from 0.
    // Inside a state the counter saturates instead of wrapping.
    // It stays at 0 in IDLE and DONE.
    // The byte is captured on the edge that ends the last RD_LOW cycle.
    // At that point rd_n has been low for the whole phase.
    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        phase_end = (cnt == LAST);
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = ADDR_SET;
                    addr_d  = addr;
                end
            end
            ADDR_SET:  if (phase_end) state_d = ADDR_WR;
            ADDR_WR:   if (phase_end) state_d = ADDR_HOLD;
            ADDR_HOLD: if (phase_end) state_d = TURN;
            TURN:      if (phase_end) state_d = RD_LOW;
            RD_LOW: begin
                if (phase_end) begin
                    state_d = RECOVER;
                    capture = 1'b1;
                end
            end
            RECOVER:   if (phase_end) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        if (state_d != state || state == IDLE || state == DONE) begin
            cnt_d = '0;
        end else if (phase_end) begin
            cnt_d = cnt;
        end else begin
            cnt_d = cnt + 1'b1;
        end
    end

    // Pin values for the coming cycle are decoded from the next state.
    // This lets the registered outputs change on the same edge as the state.
    // During the accept edge, addr_d already carries the new address.
    // The bus is only driven in the three address phases.
    // RD_LOW never drives the bus, so the RTC and this master never both drive it.
    always_comb begin
        drive_d  = '0;
        oe_d     = 1'b0;
        cs_n_d   = 1'b1;
        ad_sel_d = 1'b0;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        case (state_d)
            ADDR_SET, ADDR_HOLD: begin
                cs_n_d  = 1'b0;
                oe_d    = 1'b1;
                drive_d = addr_d;
            end
            ADDR_WR: begin
                cs_n_d  = 1'b0;
                oe_d    = 1'b1;
                drive_d = addr_d;
                wr_n_d  = 1'b0;
            end
            TURN, RECOVER: begin
                cs_n_d   = 1'b0;
                ad_sel_d = 1'b1;
            end
            RD_LOW: begin
                cs_n_d   = 1'b0;
                ad_sel_d = 1'b1;
                rd_n_d   = 1'b0;
            end
            DONE:    done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // State register and registered outputs.
    // Reset releases the bus and raises every strobe immediately.
    // Reset also clears the captured byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_out  <= '0;
            bus_drive <= '0;
            bus_oe    <= 1'b0;
            cs_n      <= 1'b1;
            ad_sel    <= 1'b0;
            wr_n      <= 1'b1;
            rd_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            addr_q    <= addr_d;
            bus_drive <= drive_d;
            bus_oe    <= oe_d;
            cs_n      <= cs_n_d;
            ad_sel    <= ad_sel_d;
            wr_n      <= wr_n_d;
            rd_n      <= rd_n_d;
            busy      <= busy_d;
            done      <= done_d;
            if (capture) begin
                data_out <= bus_in;
            end
        end
    end

`ifdef RTC_BCD_CHECK_EN
    // The BCD flag is updated on the capture edge, together with data_out.
    // It checks the two low nibbles, which hold the RTC's BCD digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_err <= 1'b0;
        end else if (capture) begin
            bcd_err <= (bus_in[7:4] > 4'd9) || (bus_in[3:0] > 4'd9);
        end
    end
`endif

endmodule

// File: tb/tb_rtc_bus_read_ctrl.sv
// tb_rtc_bus_read_ctrl
// Drives two sequencers: one with PHASE_CYCLES=4 and one with PHASE_CYCLES=1.
// Each read is described by its address, the byte the RTC returns, and the edge it is accepted on.
// Those descriptions go into a shared expectation queue.
// A monitor compares every cycle's pins against a phase table derived from the cycle offset.
// On each done pulse, it also checks the captured byte.
module tb_rtc_bus_read_ctrl;

    localparam int PC0 = 4;
    localparam int PC1 = 1;

    typedef struct {
        int         inst;
        logic [7:0] addr;
        logic [7:0] data;
        int         acc;
    } txn_t;

    logic       clk;
    logic       rst_n_v     [2];
    logic       start_v     [2];
    logic [7:0] addr_v      [2];
    logic [7:0] data_out_v  [2];
    logic       busy_v      [2];
    logic       done_v      [2];
    logic [7:0] bus_in_v    [2];
    logic [7:0] drive_v     [2];
    logic       oe_v        [2];
    logic       cs_n_v      [2];
    logic       ad_sel_v    [2];
    logic       wr_n_v      [2];
    logic       rd_n_v      [2];
`ifdef RTC_BCD_CHECK_EN
    logic       bcd_err_v   [2];
`endif

    int   cyc;
    int   n_vec;
    int   n_err;
    int   last_done [2];
    txn_t exp_q[$];

    rtc_bus_read_ctrl #(.PHASE_CYCLES(PC0), .ADDR_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .addr(addr_v[0]),
        .data_out(data_out_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .bus_in(bus_in_v[0]), .bus_drive(drive_v[0]), .bus_oe(oe_v[0]),
        .cs_n(cs_n_v[0]), .ad_sel(ad_sel_v[0]), .wr_n(wr_n_v[0]), .rd_n(rd_n_v[0])
`ifdef RTC_BCD_CHECK_EN
       ,.bcd_err(bcd_err_v[0])
`endif
    );

    rtc_bus_read_ctrl #(.PHASE_CYCLES(PC1), .ADDR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .addr(addr_v[1]),
        .data_out(data_out_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .bus_in(bus_in_v[1]), .bus_drive(drive_v[1]), .bus_oe(oe_v[1]),
        .cs_n(cs_n_v[1]), .ad_sel(ad_sel_v[1]), .wr_n(wr_n_v[1]), .rd_n(rd_n_v[1])
`ifdef RTC_BCD_CHECK_EN
       ,.bcd_err(bcd_err_v[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pc_of(input int i);
        return (i == 0) ? PC0 : PC1;
    endfunction

    function automatic int front(input int i);
        foreach (exp_q[j]) begin
            if (exp_q[j].inst == i) return j;
        end
        return -1;
    endfunction

    // Reference pin table.
    // The phase index is the cycle offset from acceptance divided by the phase length.
    // Bit order: {busy, done, cs_n, ad_sel, bus_oe, wr_n, rd_n, bus_drive[7:0]}.
    function automatic logic [14:0] model_pins(input int pc, input int k, input logic [7:0] a);
        int ph;
        ph = k / pc;
        if (k >= 6 * pc) ph = 6;
        return {1'b1, (ph == 6), (ph == 6), (ph >= 3 && ph <= 5), (ph < 3),
                (ph != 1), (ph != 4), (ph < 3) ? a : 8'h00};
    endfunction

    function automatic logic [14:0] idle_pins();
        return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle monitor for one instance.
    // It also plays the RTC side of the bus.
    // The returned byte appears only during the read-strobe phase.
    // At all other times bus_in carries its complement, so a capture on the wrong edge shows up.
    task automatic monitor(input int i);
        int          f;
        int          k;
        int          pc;
        logic [14:0] act;
        pc  = pc_of(i);
        f   = front(i);
        act = {busy_v[i], done_v[i], cs_n_v[i], ad_sel_v[i], oe_v[i], wr_n_v[i], rd_n_v[i], drive_v[i]};
        if (f >= 0 && cyc >= exp_q[f].acc) begin
            k = cyc - exp_q[f].acc;
            check_output($sformatf("pins[%0d] k=%0d", i, k), 32'(act), 32'(model_pins(pc, k, exp_q[f].addr)));
            bus_in_v[i] = ((k / pc) == 4) ? exp_q[f].data : ~exp_q[f].data;
            if (k >= 6 * pc) begin
                check_output($sformatf("data_out[%0d]", i), 32'(data_out_v[i]), 32'(exp_q[f].data));
`ifdef RTC_BCD_CHECK_EN
                check_output($sformatf("bcd_err[%0d]", i), 32'(bcd_err_v[i]),
                             32'((exp_q[f].data[7:4] > 4'd9) || (exp_q[f].data[3:0] > 4'd9)));
`endif
                exp_q.delete(f);
            end
        end else begin
            check_output($sformatf("idle pins[%0d]", i), 32'(act), 32'(idle_pins()));
            bus_in_v[i] = 8'($urandom);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) monitor(i);
    end

    // Issues one read.
    // start stays high until the model's acceptance edge has passed.
    // A call made while the instance is busy therefore holds start through DONE.
    task automatic apply_stimulus(input int i, input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        int   acc;
        acc = cyc + 1;
        if (last_done[i] + 2 > acc) acc = last_done[i] + 2;
        t.inst = i;
        t.addr = a;
        t.data = d;
        t.acc  = acc;
        exp_q.push_back(t);
        last_done[i] = acc + 6 * pc_of(i);
        start_v[i] = 1'b1;
        addr_v[i]  = a;
        for (int n = 0; n < 2000 && cyc < acc; n++) @(negedge clk);
        start_v[i] = 1'b0;
        addr_v[i]  = 8'($urandom);
    endtask

    task automatic wait_drain(input int i);
        for (int n = 0; n < 1000 && front(i) >= 0; n++) @(negedge clk);
        check_output($sformatf("drain[%0d]", i), 32'(front(i) >= 0), 32'd0);
    endtask

    task automatic purge(input int i);
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
            if (exp_q[j].inst == i) exp_q.delete(j);
        end
        last_done[i] = -100;
    endtask

    task automatic random_reads(input int i, input int count);
        int gap;
        for (int r = 0; r < count; r++) begin
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25));
            repeat (gap) @(negedge clk);
            apply_stimulus(i, 8'($urandom), 8'($urandom));
        end
        wait_drain(i);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 2; i++) begin
            rst_n_v[i]   = 1'b0;
            start_v[i]   = 1'b0;
            addr_v[i]    = 8'h00;
            bus_in_v[i]  = 8'h00;
            last_done[i] = -100;
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_output("reset data_out", 32'(data_out_v[i]), 32'h0);
            check_output("reset busy", 32'(busy_v[i]), 32'h0);
            check_output("reset cs_n", 32'(cs_n_v[i]), 32'h1);
        end
        rst_n_v[0] = 1'b1;
        rst_n_v[1] = 1'b1;
        repeat (2) @(negedge clk);

        // Basic read. A second start with a different address arrives mid-read and must be ignored.
        apply_stimulus(0, 8'h21, 8'h59);
        repeat (10) @(negedge clk);
        start_v[0] = 1'b1;
        addr_v[0]  = 8'h33;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_drain(0);
        repeat (5) @(negedge clk);

        // A non-BCD byte.
        apply_stimulus(0, 8'h07, 8'h5A);
        wait_drain(0);

        // Reset during RD_LOW. The bus must be released at once, and there is no done pulse.
        apply_stimulus(0, 8'h44, 8'h12);
        repeat (17) @(negedge clk);
        #2;
        rst_n_v[0] = 1'b0;
        purge(0);
        #1;
        check_output("mid-reset rd_n", 32'(rd_n_v[0]), 32'h1);
        check_output("mid-reset cs_n", 32'(cs_n_v[0]), 32'h1);
        check_output("mid-reset bus_oe", 32'(oe_v[0]), 32'h0);
        check_output("mid-reset data_out", 32'(data_out_v[0]), 32'h0);
        check_output("mid-reset busy", 32'(busy_v[0]), 32'h0);
        repeat (2) @(negedge clk);
        rst_n_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        apply_stimulus(0, 8'h21, 8'h59);
        wait_drain(0);

        // Back-to-back: the second start is held high through the DONE cycle.
        apply_stimulus(0, 8'h10, 8'h31);
        apply_stimulus(0, 8'h11, 8'h47);
        wait_drain(0);

        random_reads(0, 8);

        // Single-cycle phases.
        apply_stimulus(1, 8'h00, 8'hFF);
        wait_drain(1);
        apply_stimulus(1, 8'h3C, 8'h99);
        apply_stimulus(1, 8'hC3, 8'h00);
        wait_drain(1);
        random_reads(1, 10);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_bus_read_ctrl.md
Name: rtc_bus_read_ctrl

Overview:
- Master-side read sequencer for the RTC's multiplexed 8-bit address/data bus.
- Runs the full read cycle: drives the register address, strobes it in, releases the bus, pulses RD, captures the returned byte.
- Controls the existing output tristate buffer through bus_drive/bus_oe; reads the pad value back on bus_in.
- Sits between the clock/date register-scan logic (start/addr/data_out) and the RTC pins.

Parameters:
- PHASE_CYCLES, 4, clock cycles per bus phase; legal range 1..255.
- ADDR_W, 8, width of address and data bus.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  read request; sampled only in IDLE.
- addr  in  ADDR_W  RTC register address; latched when start is accepted.
- data_out  out  ADDR_W  last byte read; holds until the next capture.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle pulse; data_out is valid in that cycle.
- bus_in  in  ADDR_W  pad value of the shared bus.
- bus_drive  out  ADDR_W  value for the tristate buffer.
- bus_oe  out  1  tristate enable; 1 = drive bus_drive onto the pins.
- cs_n  out  1  RTC chip select, active low.
- ad_sel  out  1  0 = address phase, 1 = data phase.
- wr_n  out  1  write strobe, active low.
- rd_n  out  1  read strobe, active low.

Behaviour:
- Reset (async, immediate):
  - State IDLE; phase counter 0.
  - data_out = 0, busy = 0, done = 0, bus_drive = 0, bus_oe = 0.
  - cs_n = 1, wr_n = 1, rd_n = 1, ad_sel = 0.
  - Reset mid-cycle releases the bus and deasserts all strobes at once. No done pulse; data_out is cleared.
- Accept: in IDLE with start = 1 at edge E0:
  - addr is latched into an internal register; the FSM enters ADDR_SET.
  - start outside IDLE is ignored. No queueing.
- Each state ADDR_SET..RECOVER lasts exactly PHASE_CYCLES cycles, timed by the phase counter, which resets on every state change. Outputs are registered.
  - ADDR_SET: cs_n = 0, ad_sel = 0, bus_oe = 1, bus_drive = latched addr, wr_n = 1, rd_n = 1.
  - ADDR_WR: as ADDR_SET, plus wr_n = 0.
  - ADDR_HOLD: wr_n = 1; bus_oe stays 1; bus_drive is held.
  - TURN: bus_oe = 0, bus_drive = 0, ad_sel = 1, cs_n = 0, all strobes high. Bus turnaround, no contention.
  - RD_LOW: rd_n = 0, bus_oe = 0. On the edge ending RD_LOW's last cycle, data_out <= bus_in.
  - RECOVER: rd_n = 1, cs_n = 0.
  - DONE (1 cycle): cs_n = 1, ad_sel = 0, done = 1, busy = 1. Then IDLE.
- Latency:
  - DONE occupies the cycle starting 6*PHASE_CYCLES edges after E0.
  - PHASE_CYCLES = 4 gives done at E0+24.
- Back-to-back: a start asserted during DONE is ignored. A new start is accepted no earlier than the first IDLE cycle.
- Invariants:
  - bus_oe and rd_n = 0 are never simultaneously true.
  - wr_n = 0 and rd_n = 0 are never simultaneously true.
  - The phase counter is sized for PHASE_CYCLES and saturates at the terminal count; no wrap-around.

Optional Feature:
- RTC_BCD_CHECK_EN defined:
  - Adds output bcd_err (1 bit, reset 0), updated at the same edge as data_out.
  - bcd_err = 1 if either nibble of the captured byte is > 9, else 0.
  - Held until the next capture; valid alongside done.
- Undefined: no bcd_err port and no check logic; all other behaviour identical.

Test Plan:
- PHASE_CYCLES = 4, start with addr = 0x21; bench returns 0x59 on bus_in while rd_n = 0.
  - bus_drive = 0x21 with bus_oe = 1 for cycles E0..E0+11.
  - wr_n low E0+4..E0+7; rd_n low E0+16..E0+19.
  - done at E0+24, data_out = 0x59.
- start re-pulsed with addr = 0x33 at E0+10.
  - Ignored: bus_drive stays 0x21; exactly one done.
- rst_n low at E0+17 (in RD_LOW).
  - Same cycle: rd_n = cs_n = 1, bus_oe = 0, data_out = 0x00, busy = 0.
  - No done pulse; a fresh start after release completes normally.
- PHASE_CYCLES = 1, addr = 0x00, bus_in = 0xFF.
  - done at E0+6, data_out = 0xFF.
  - No cycle has bus_oe = 1 together with rd_n = 0.
- Two reads: second start held high through the DONE cycle.
  - Accepted in the first IDLE cycle; second done follows 6*PHASE_CYCLES later, with data_out = second returned byte.
- RTC_BCD_CHECK_EN: returned byte 0x5A gives bcd_err = 1; 0x59 gives 0.
  - With the macro undefined the build has no bcd_err port.
